detect_programmable_sequence_fsm: RTL
=====================================

# detect_programmable_sequence_fsm

Serial bit-sequence detector with a runtime-loadable pattern of 1 to MAX_LEN bits and a selectable overlap mode. It is the parametrised successor to the fixed 4-bit and 6-bit sequence detectors. It tracks the matched prefix length with a failure-function (KMP-style) state machine, so no input history is replayed. It adds a saturating match counter and exposes the current FSM state for debug.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits; must be ≥ 2.
- CNT_W, default 8: width of the match counter.
- LEN_W, default $clog2(MAX_LEN+1): width of the len and prefix_len fields (derived; do not override).
- clk  input  1  clock; all registers update on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- a  input  1  serial data bit; sampled only when en = 1.
- en  input  1  bit-valid; when en = 0 the a input is ignored and all state holds.
- cfg_load  input  1  when high at a clock edge, latches pattern, len and overlap.
- pattern  input  MAX_LEN  sequence to detect. The first bit received is compared against pattern[len-1] and the last against pattern[0].
- len  input  LEN_W  pattern length. 0 disables detection. Values above MAX_LEN are clamped to MAX_LEN.
- overlap  input  1  1 = overlapping matches are detected; 0 = the FSM restarts from empty after each match.
- detected  output  1  registered one-cycle pulse per match.
- match_cnt  output  CNT_W  number of matches since reset or the last cfg_load; saturates at all-ones.
- prefix_len  output  LEN_W  current FSM state k, the number of pattern bits currently matched (0..len-1).

## Operation
- Configuration registers: cfg_pattern, cfg_len and cfg_ovl. They are loaded only by cfg_load and reset to 0, 0 and 0. After reset, detection is therefore disabled until the first cfg_load.
- State k ranges over 0..cfg_len-1; k = i means the last i accepted bits equal the first i pattern bits.
- When en = 1, cfg_load = 0 and cfg_len ≠ 0, let p = the pattern bit at index k, i.e. pattern[cfg_len-1-k].
  - If a = p and k < cfg_len-1: next k = k+1.
  - If a = p and k = cfg_len-1: this is a match. Assert detected next cycle and increment match_cnt unless it is already saturated. Next k = cfg_ovl ? B(cfg_len) : 0, where B(n) is the length of the longest proper border (prefix that is also a suffix) of the first n pattern bits.
  - If a ≠ p: next k = the largest j ≤ k such that the last j accepted bits, including a, equal the first j pattern bits. This is computed combinationally as an explicit search over candidate j = k down to 0. It must not use a stored input history.
- Patterns with cfg_len = 1 work in both modes: every accepted bit equal to the pattern bit is a match, and k stays 0.
- cfg_load = 1:
  - Latch the config registers, clamping len.
  - Force k = 0, detected = 0 and match_cnt = 0.
  - The a bit in that cycle is discarded, whatever the value of en.
- cfg_load has priority over en.
- Changing pattern, len or overlap without cfg_load has no effect.
- cfg_len = 0: k holds 0, detected stays 0, match_cnt holds.
- en = 0: k, match_cnt and the config registers hold; detected is 0 in the following cycle.

## Timing
- Reset (rst low, asynchronous): detected = 0, match_cnt = 0, prefix_len = 0, config registers = 0. Release is synchronous to clk through the normal reset synchroniser; the first edge after release is a normal cycle.
- Latency: detected goes high in the cycle after the clock edge that sampled the final pattern bit. It lasts exactly one cycle per match.
- Back-to-back matches are possible in overlap mode (for example pattern 11 on input 111). detected then stays high for consecutive cycles, and match_cnt increments on each.
- match_cnt and prefix_len update on the same edge as detected; prefix_len shows the post-transition k.
- Saturation: once match_cnt is all-ones it holds, while detected still pulses.
- Reset asserted mid-sequence: all state clears immediately. Any partial match is lost and the pattern must be reloaded.

## Test plan
- Overlap mode: cfg_load with pattern=1010, len=4, overlap=1, then feed 1,0,1,0,1,0 with en=1 → detected high after bits 4 and 6; match_cnt=2; prefix_len after bit 4 = 2.
- Non-overlap mode: same stimulus with overlap=0 → a single detected pulse after bit 4; match_cnt=1; prefix_len=2 at the end.
- Failure transitions: pattern=110110 (len 6), overlap=1, input 1,1,1,0,1,1,0,1,1,0 → detected after bits 7 and 10. prefix_len reads 2 after bit 3 (mismatch 1 following 11), not 0.
- en gaps: pattern=1001, len=4, input 1,0,(en=0 for 3 cycles with a toggling),0,1 → exactly one detected pulse, after the final 1. detected and prefix_len are frozen during the gap.
- Saturation and length clamp:
  - CNT_W=2, pattern=1, len=1, 5 ones → detected high 5 consecutive cycles; match_cnt goes 1, 2, 3, 3, 3.
  - len=15 with MAX_LEN=8 behaves as len=8.
- Config and reset: cfg_load in the middle of a partial match → prefix_len=0 and match_cnt=0 next cycle. With len=0 loaded, random input → detected never asserts. rst pulled low asynchronously mid-stream → all outputs 0 before the next edge.

Source files
------------

// File: rtl/detect_programmable_sequence_fsm.sv
// Serial bit-sequence detector with a runtime-loadable pattern of 1..MAX_LEN
// bits. The matched prefix length k is advanced with a failure-function
// search over the stored pattern only, so no input history is kept.
module detect_programmable_sequence_fsm #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   prefix_len
);

  logic [MAX_LEN-1:0] cfg_pattern_q, cfg_pattern_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic               cfg_ovl_q, cfg_ovl_d;
  logic [LEN_W-1:0]   k_q, k_d;
  logic               detected_q, detected_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;

  // pord[i] is the i-th pattern bit in arrival order (pattern[len-1-i])
  logic [MAX_LEN-1:0] pord;
  logic [LEN_W-1:0]   border;
  logic [LEN_W-1:0]   fail_k;
  logic               border_ok;
  logic               fail_ok;
  logic               pbit;

  // Re-order the stored pattern so index 0 is the first bit expected
  always_comb begin
    pord = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (i < 32'(cfg_len_q)) begin
        pord[i] = 1'(cfg_pattern_q >> (32'(cfg_len_q) - 32'd1 - i));
      end
    end
  end

  // Longest proper border of the full pattern: restart point after a match
  always_comb begin
    border    = '0;
    border_ok = 1'b0;
    for (int unsigned b = 1; b < MAX_LEN; b++) begin
      if (b < 32'(cfg_len_q)) begin
        border_ok = 1'b1;
        for (int unsigned m = 0; m < MAX_LEN; m++) begin
          if (m < b &&
              (1'(pord >> m) != 1'(pord >> (32'(cfg_len_q) - b + m)))) begin
            border_ok = 1'b0;
          end
        end
        if (border_ok) begin
          border = LEN_W'(b);
        end
      end
    end
  end

  // Mismatch fallback: largest j <= k whose last j-1 matched bits plus a
  // form a pattern prefix; the matched bits are known to be pord[0..k-1]
  always_comb begin
    fail_k  = '0;
    fail_ok = 1'b0;
    for (int unsigned j = 1; j < MAX_LEN; j++) begin
      if (j <= 32'(k_q)) begin
        fail_ok = (1'(pord >> (j - 32'd1)) == a);
        for (int unsigned m = 0; m < MAX_LEN; m++) begin
          if (m + 32'd1 < j &&
              (1'(pord >> m) != 1'(pord >> (32'(k_q) - j + 32'd1 + m)))) begin
            fail_ok = 1'b0;
          end
        end
        if (fail_ok) begin
          fail_k = LEN_W'(j);
        end
      end
    end
  end

  // Next-state, match pulse, counter and configuration update
  always_comb begin
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_ovl_d     = cfg_ovl_q;
    k_d           = k_q;
    detected_d    = 1'b0;
    match_cnt_d   = match_cnt_q;
    pbit          = 1'(pord >> k_q);
    if (cfg_load) begin
      cfg_pattern_d = pattern;
      cfg_len_d     = (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
      cfg_ovl_d     = overlap;
      k_d           = '0;
      match_cnt_d   = '0;
    end else if (en && cfg_len_q != '0) begin
      if (a == pbit) begin
        if (k_q == cfg_len_q - LEN_W'(1)) begin
          detected_d = 1'b1;
          if (match_cnt_q != '1) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
          k_d = cfg_ovl_q ? border : '0;
        end else begin
          k_d = k_q + LEN_W'(1);
        end
      end else begin
        k_d = fail_k;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_ovl_q     <= 1'b0;
      k_q           <= '0;
      detected_q    <= 1'b0;
      match_cnt_q   <= '0;
    end else begin
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_ovl_q     <= cfg_ovl_d;
      k_q           <= k_d;
      detected_q    <= detected_d;
      match_cnt_q   <= match_cnt_d;
    end
  end

  assign detected   = detected_q;
  assign match_cnt  = match_cnt_q;
  assign prefix_len = k_q;

endmodule
